// File: rtl/boq_pkg.sv
// Shared types, sizes and helpers for the branch outcome queue.
package boq_pkg;

    localparam int AMSB   = 79;               // MSB of instruction pointer
    localparam int NSLOTS = 4;                // commit slots per cycle
    localparam int DEPTH  = 16;               // FIFO entries, power of two, >= 2*NSLOTS
    localparam int PTR_W  = $clog2(DEPTH);    // head/tail pointer width
    localparam int CNT_W  = PTR_W + 1;        // occupancy width, holds 0..DEPTH

    typedef struct packed {
        logic [AMSB:0] ip;
        logic          takb;
    } boq_entry_t;

    // Number of set bits in a slot mask.
    function automatic logic [CNT_W-1:0] popcount(input logic [NSLOTS-1:0] v);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            sum = sum + CNT_W'(v[i]);
        end
        return sum;
    endfunction

    // 32-bit counter increment that sticks at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [CNT_W-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/branch_outcome_queue_if.sv
// Predictor update port: one branch outcome per handshake.
interface branch_outcome_queue_if;
    import boq_pkg::*;

    logic          upd_valid;
    logic          upd_ready;
    logic [AMSB:0] upd_ip;
    logic          upd_takb;

    // Queue side drives the outcome, predictor side accepts it.
    modport master (output upd_valid, output upd_ip, output upd_takb, input upd_ready);
    modport slave  (input upd_valid, input upd_ip, input upd_takb, output upd_ready);

endinterface

// File: rtl/boq_compact.sv
// Report mask and compaction offsets for one commit group: slots after the first
// taken branch are shadowed, survivors get dense write offsets in slot order.
module boq_compact
    import boq_pkg::*;
(
    input  logic                             en,
    input  logic [NSLOTS-1:0]                cmt_v,
    input  logic [NSLOTS-1:0]                cmt_br,
    input  logic [NSLOTS-1:0]                cmt_takb,
    output logic [NSLOTS-1:0]                rep,
    output logic [NSLOTS-1:0][PTR_W-1:0]     offs,
    output logic [CNT_W-1:0]                 npush
);

    logic             shadow;
    logic [CNT_W-1:0] run;

    // Walk slots in order, tracking whether an earlier taken branch shadows this one.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        rep    = '0;
        offs   = '0;
        shadow = 1'b0;
        run    = '0;
        for (int n = 0; n < NSLOTS; n++) begin
            rep[n]  = en & cmt_v[n] & cmt_br[n] & ~shadow;
            offs[n] = PTR_W'(run);
            run     = run + CNT_W'(rep[n]);
            shadow  = shadow | (cmt_v[n] & cmt_br[n] & cmt_takb[n]);
        end
        npush = popcount(rep);
    end

endmodule

// File: rtl/branch_outcome_queue.sv
// Commit-side branch outcome queue feeding the g-share update port.
// Optional feature: define BOQ_MISPREDICT_STATS_EN to add saturating
// reported-branch and mispredict counters (stat_br, stat_mp).
module branch_outcome_queue
    import boq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NSLOTS-1:0]            cmt_v,
    input  logic [NSLOTS-1:0]            cmt_br,
    input  logic [NSLOTS-1:0]            cmt_takb,
    input  logic [NSLOTS-1:0]            cmt_pred,
    input  logic [NSLOTS-1:0][AMSB:0]    cmt_ip,
    output logic                         cmt_stall,
    branch_outcome_queue_if.master       upd,
    output logic                         ovf
`ifdef BOQ_MISPREDICT_STATS_EN
   ,output logic [31:0]                  stat_br,
    output logic [31:0]                  stat_mp
`endif
);

    logic [NSLOTS-1:0]            rep;
    logic [NSLOTS-1:0][PTR_W-1:0] offs;
    logic [CNT_W-1:0]             npush;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, wr_idx;
    logic [CNT_W-1:0] count_q, count_d, free, nwr;
    logic             ovf_q, ovf_d, pop, drop;
    boq_entry_t       mem_q [DEPTH];
    boq_entry_t       mem_d [DEPTH];

    boq_compact u_compact (
        .en       (en),
        .cmt_v    (cmt_v),
        .cmt_br   (cmt_br),
        .cmt_takb (cmt_takb),
        .rep      (rep),
        .offs     (offs),
        .npush    (npush)
    );

    // Push/pop bookkeeping; a group that does not fit is dropped whole.
    always_comb begin
        free    = CNT_W'(DEPTH) - count_q;
        pop     = (count_q != '0) & upd.upd_ready;
        drop    = npush > free;
        nwr     = drop ? '0 : npush;
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(nwr);
        count_d = count_q + nwr - CNT_W'(pop);
        ovf_d   = ovf_q | drop;
        mem_d   = mem_q;
        wr_idx  = '0;
        for (int n = 0; n < NSLOTS; n++) begin
            if (rep[n] && !drop) begin
                wr_idx              = tail_q + offs[n];
                mem_d[wr_idx].ip    = cmt_ip[n];
                mem_d[wr_idx].takb  = cmt_takb[n];
            end
        end
    end

    // Pointer, occupancy and sticky overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates visibility, so stale entries are never read.
        mem_q <= mem_d;
    end

    assign cmt_stall     = free < CNT_W'(NSLOTS);
    assign ovf           = ovf_q;
    assign upd.upd_valid = (count_q != '0);
    assign upd.upd_ip    = mem_q[head_q].ip;
    assign upd.upd_takb  = mem_q[head_q].takb;

`ifdef BOQ_MISPREDICT_STATS_EN
    logic [31:0]      stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
    logic [CNT_W-1:0] nmp;

    // Count only groups that were actually written.
    always_comb begin
        nmp       = drop ? '0 : popcount(rep & (cmt_pred ^ cmt_takb));
        stat_br_d = sat_add32(stat_br_q, nwr);
        stat_mp_d = sat_add32(stat_mp_q, nmp);
    end

    // Statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_br = stat_br_q;
    assign stat_mp = stat_mp_q;
`else
    logic unused_pred;
    assign unused_pred = ^cmt_pred;
`endif

endmodule

// File: tb/tb_branch_outcome_queue.sv
// Self-checking bench for branch_outcome_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_branch_outcome_queue;
    import boq_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      en  = 1'b0;
    logic [NSLOTS-1:0]         cmt_v = '0, cmt_br = '0, cmt_takb = '0, cmt_pred = '0;
    logic [NSLOTS-1:0][AMSB:0] cmt_ip = '0;
    logic                      cmt_stall, ovf;
`ifdef BOQ_MISPREDICT_STATS_EN
    logic [31:0]               stat_br, stat_mp;
`endif

    branch_outcome_queue_if upd_if();

    always #5 clk = ~clk;

    branch_outcome_queue dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmt_v     (cmt_v),
        .cmt_br    (cmt_br),
        .cmt_takb  (cmt_takb),
        .cmt_pred  (cmt_pred),
        .cmt_ip    (cmt_ip),
        .cmt_stall (cmt_stall),
        .upd       (upd_if),
        .ovf       (ovf)
`ifdef BOQ_MISPREDICT_STATS_EN
       ,.stat_br   (stat_br),
        .stat_mp   (stat_mp)
`endif
    );

    // Reference model state.
    boq_entry_t mq[$];
    logic       m_ovf = 1'b0;
    longint     m_br  = 0;
    longint     m_mp  = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("upd_valid", 128'(upd_if.upd_valid), 128'(mq.size() != 0));
        check("cmt_stall", 128'(cmt_stall), 128'((DEPTH - mq.size()) < NSLOTS));
        check("ovf", 128'(ovf), 128'(m_ovf));
        if (mq.size() != 0) begin
            check("upd_ip", 128'(upd_if.upd_ip), 128'(mq[0].ip));
            check("upd_takb", 128'(upd_if.upd_takb), 128'(mq[0].takb));
        end
`ifdef BOQ_MISPREDICT_STATS_EN
        check("stat_br", 128'(stat_br), 128'(m_br));
        check("stat_mp", 128'(stat_mp), 128'(m_mp));
`endif
    endtask

    // Effect of the coming clock edge, from the current inputs.
    task automatic model_apply();
        int               first_tk = NSLOTS;
        int               npush = 0;
        int               nmp = 0;
        int               free;
        logic             do_pop;
        logic [NSLOTS-1:0] rep = '0;
        boq_entry_t       e;
        for (int n = 0; n < NSLOTS; n++)
            if (cmt_v[n] && cmt_br[n] && cmt_takb[n] && first_tk == NSLOTS) first_tk = n;
        for (int n = 0; n < NSLOTS; n++) begin
            rep[n] = en && cmt_v[n] && cmt_br[n] && (n <= first_tk);
            if (rep[n]) begin
                npush++;
                if (cmt_pred[n] != cmt_takb[n]) nmp++;
            end
        end
        free   = DEPTH - mq.size();
        do_pop = (mq.size() != 0) && upd_if.upd_ready;
        if (do_pop) void'(mq.pop_front());
        if (npush > free) begin
            m_ovf = 1'b1;
        end else begin
            for (int n = 0; n < NSLOTS; n++) begin
                if (rep[n]) begin
                    e.ip   = cmt_ip[n];
                    e.takb = cmt_takb[n];
                    mq.push_back(e);
                end
            end
            m_br = (m_br + npush > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_br + npush;
            m_mp = (m_mp + nmp   > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mp + nmp;
        end
    endtask

    // One cycle: check at negedge, drive inputs, advance model, wait next negedge.
    task automatic step(input logic e, input logic [NSLOTS-1:0] v, input logic [NSLOTS-1:0] br,
                        input logic [NSLOTS-1:0] tk, input logic [NSLOTS-1:0] pr, input logic rdy,
                        input logic [NSLOTS-1:0][AMSB:0] ips);
        check_outputs();
        en               = e;
        cmt_v            = v;
        cmt_br           = br;
        cmt_takb         = tk;
        cmt_pred         = pr;
        cmt_ip           = ips;
        upd_if.upd_ready = rdy;
        model_apply();
        @(negedge clk);
    endtask

    function automatic logic [NSLOTS-1:0][AMSB:0] rand_ips();
        logic [NSLOTS-1:0][AMSB:0] r;
        for (int n = 0; n < NSLOTS; n++) r[n] = (AMSB + 1)'({$urandom(), $urandom(), $urandom()});
        return r;
    endfunction

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) step(1'b1, '0, '0, '0, '0, rdy, rand_ips());
    endtask

    logic [NSLOTS-1:0][AMSB:0] abcd;
    logic [NSLOTS-1:0]         rv;
    logic                      stall_pred;

    initial begin
        upd_if.upd_ready = 1'b0;
        abcd[0] = 80'hAAAA_0000_1111_0000_0A00;
        abcd[1] = 80'hBBBB_0000_2222_0000_0B00;
        abcd[2] = 80'hCCCC_0000_3333_0000_0C00;
        abcd[3] = 80'hDDDD_0000_4444_0000_0D00;

        // 1. Reset and idle.
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b1);

        // 2. Four not-taken branches, drained in order.
        step(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 1'b1, abcd);
        idle(5, 1'b1);

        // 3. Taken branch in slot 1 shadows slots 2 and 3.
        step(1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 1'b1, abcd);
        idle(3, 1'b1);

        // en=0 ignores a full group.
        step(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, abcd);
        idle(1, 1'b1);

        // 4. Fill with ready low; stall rises near full, head stays put.
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0011, 1'b0, rand_ips());
        idle(2, 1'b0);
        idle(2, 1'b1);

        // 5. Count is 14: ignoring stall drops the whole group, ovf sticks.
        step(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, rand_ips());
        idle(1, 1'b0);
        step(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, rand_ips());
        idle(18, 1'b1);

        // 6. Random traffic across many pointer wraps.
        for (int i = 0; i < 400; i++) begin
            stall_pred = (DEPTH - mq.size()) < NSLOTS;
            rv = (stall_pred && ($urandom_range(0, 19) != 0)) ? '0 : NSLOTS'($urandom());
            step(($urandom_range(0, 9) != 0), rv, NSLOTS'($urandom()),
                 NSLOTS'($urandom()) & NSLOTS'($urandom()), NSLOTS'($urandom()),
                 ($urandom_range(0, 3) != 0), rand_ips());
        end
        idle(DEPTH + 2, 1'b1);

        // 7. Asynchronous reset mid-operation empties the queue.
        for (int i = 0; i < 2; i++) step(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1010, 1'b0, rand_ips());
        check_outputs();
        en     = 1'b0;
        cmt_v  = '0;
        #2 rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_br  = 0;
        m_mp  = 0;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
